// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
// Owns the ball for a 640x480 pixel-domain raster. Keeps position and
// velocity, bounces off the side and top walls, and bounces back up when
// a collision edge is reported. Reaching the bottom edge without a hit
// hides the ball for RESPAWN_FRAMES frames before it respawns.
//
// Ports:
//   clk_25MHz          pixel clock
//   reset_n            synchronous active-low reset
//   x_pixel, y_pixel   current raster position
//   display_en         high in the active area
//   collision_detected rising edge requests a bounce
//   is_hit_area        current pixel inside the visible ball (combinational)
//   ball_on            same as is_hit_area, for the overlay mixer
//   ball_x, ball_y     registered top-left ball position
//   hit_pulse          one-cycle pulse per accepted hit
//   hit_count          wrap-around count of accepted hits
//   miss_count         wrap-around count of misses
//
// Optional feature macro: BALL_SPEEDUP_EN (each accepted hit raises the
// speed by one, up to MAX_SPEED; respawn restores SPEED).
module ball_motion_ctrl #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned BALL_SIZE       = 16,
  parameter int unsigned SPEED           = 2,
  parameter int unsigned MAX_SPEED       = 6,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned RESPAWN_FRAMES  = 60,
  parameter int unsigned INIT_X          = 312,
  parameter int unsigned INIT_Y          = 100
) (
  input  logic       clk_25MHz,
  input  logic       reset_n,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       display_en,
  input  logic       collision_detected,
  output logic       is_hit_area,
  output logic       ball_on,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit_pulse,
  output logic [7:0] hit_count,
  output logic [7:0] miss_count
);

  typedef enum logic [1:0] {ST_MOVE, ST_COOLDOWN, ST_MISS} state_t;

  localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] SIZE     = 11'(BALL_SIZE);
  localparam logic [2:0]  SPD_MAX  = 3'(MAX_SPEED);
  // Starting speed never exceeds the ceiling.
  localparam logic [2:0]  SPD_INIT = (SPEED > MAX_SPEED) ? SPD_MAX : 3'(SPEED);
  localparam logic [7:0]  CD_LAST  = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0]  RS_LAST  = 8'(RESPAWN_FRAMES - 1);

  state_t     state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic       vx_neg_q, vx_neg_d;   // 1: moving left
  logic       vy_neg_q, vy_neg_d;   // 1: moving up
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       coll_prev_q, coll_prev_d;
  logic       hit_pend_q, hit_pend_d;
  logic       hit_pulse_q, hit_pulse_d;
  logic [7:0] hit_count_q, hit_count_d;
  logic [7:0] miss_count_q, miss_count_d;
  logic [2:0] spd;

`ifdef BALL_SPEEDUP_EN
  logic [2:0] spd_q, spd_d;
  assign spd = spd_q;
`else
  assign spd = SPD_INIT;
`endif

  logic        frame_end, coll_rise, edge_ok, hit_ok;
  logic [10:0] bx, by, sp, hx, hy;

  assign frame_end = display_en && (x_pixel == 10'(H_ACTIVE - 1))
                                && (y_pixel == 10'(V_ACTIVE - 1));
  assign coll_rise = collision_detected && !coll_prev_q;
  // Edges are only worth remembering while a hit could be accepted.
  assign edge_ok   = coll_rise && (state_q == ST_MOVE) && !vy_neg_q;
  assign hit_ok    = hit_pend_q && (state_q == ST_MOVE) && !vy_neg_q;

  assign bx = {1'b0, ball_x_q};
  assign by = {1'b0, ball_y_q};
  assign sp = {8'd0, spd};
  assign hx = {1'b0, x_pixel};
  assign hy = {1'b0, y_pixel};

  assign is_hit_area = display_en && (state_q != ST_MISS)
                    && (hx >= bx) && (hx < bx + SIZE)
                    && (hy >= by) && (hy < by + SIZE);
  assign ball_on    = is_hit_area;
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign hit_pulse  = hit_pulse_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d      = state_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    vx_neg_d     = vx_neg_q;
    vy_neg_d     = vy_neg_q;
    frame_cnt_d  = frame_cnt_q;
    coll_prev_d  = collision_detected;
    hit_pulse_d  = 1'b0;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
`ifdef BALL_SPEEDUP_EN
    spd_d        = spd_q;
`endif
    // Pending hit lives for one frame; an edge on the frame_end cycle
    // itself is carried into the following frame.
    hit_pend_d   = frame_end ? edge_ok : (hit_pend_q || edge_ok);

    if (frame_end) begin
      case (state_q)
        ST_MOVE, ST_COOLDOWN: begin
          if (!vx_neg_q) begin
            if (bx + sp >= X_MAX) begin
              ball_x_d = X_MAX[9:0];
              vx_neg_d = 1'b1;
            end else begin
              ball_x_d = ball_x_q + 10'(spd);
            end
          end else if (bx <= sp) begin
            ball_x_d = '0;
            vx_neg_d = 1'b0;
          end else begin
            ball_x_d = ball_x_q - 10'(spd);
          end

          if (vy_neg_q) begin
            if (by <= sp) begin
              ball_y_d = '0;
              vy_neg_d = 1'b0;
            end else begin
              ball_y_d = ball_y_q - 10'(spd);
            end
          end else if (hit_ok) begin
            vy_neg_d    = 1'b1;
            // Clamp so a hit right after a top bounce cannot wrap.
            ball_y_d    = (by <= sp) ? '0 : ball_y_q - 10'(spd);
            hit_pulse_d = 1'b1;
            hit_count_d = hit_count_q + 8'd1;
            state_d     = ST_COOLDOWN;
            frame_cnt_d = '0;
`ifdef BALL_SPEEDUP_EN
            spd_d       = (spd_q >= SPD_MAX) ? SPD_MAX : spd_q + 3'd1;
`endif
          end else if (by + sp >= Y_MAX) begin
            miss_count_d = miss_count_q + 8'd1;
            state_d      = ST_MISS;
            frame_cnt_d  = '0;
          end else begin
            ball_y_d = ball_y_q + 10'(spd);
          end

          if (state_q == ST_COOLDOWN && state_d == ST_COOLDOWN) begin
            if (frame_cnt_q == CD_LAST) begin
              state_d     = ST_MOVE;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        ST_MISS: begin
          if (frame_cnt_q == RS_LAST) begin
            state_d     = ST_MOVE;
            frame_cnt_d = '0;
            ball_x_d    = 10'(INIT_X);
            ball_y_d    = 10'(INIT_Y);
            vx_neg_d    = 1'b0;
            vy_neg_d    = 1'b0;
`ifdef BALL_SPEEDUP_EN
            spd_d       = SPD_INIT;
`endif
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        default: state_d = ST_MOVE;
      endcase
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (!reset_n) begin
      state_q      <= ST_MOVE;
      ball_x_q     <= 10'(INIT_X);
      ball_y_q     <= 10'(INIT_Y);
      vx_neg_q     <= 1'b0;
      vy_neg_q     <= 1'b0;
      frame_cnt_q  <= '0;
      coll_prev_q  <= 1'b0;
      hit_pend_q   <= 1'b0;
      hit_pulse_q  <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
`ifdef BALL_SPEEDUP_EN
      spd_q        <= SPD_INIT;
`endif
    end else begin
      state_q      <= state_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      vx_neg_q     <= vx_neg_d;
      vy_neg_q     <= vy_neg_d;
      frame_cnt_q  <= frame_cnt_d;
      coll_prev_q  <= coll_prev_d;
      hit_pend_q   <= hit_pend_d;
      hit_pulse_q  <= hit_pulse_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
`ifdef BALL_SPEEDUP_EN
      spd_q        <= spd_d;
`endif
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl (default build, constant speed 2).
// Frames are compressed: one frame is a single cycle at the last active
// pixel, so motion only depends on the count of frame_end cycles.
module tb_ball_motion_ctrl;

  logic       clk_25MHz = 1'b0;
  logic       reset_n;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic       display_en;
  logic       collision_detected;
  logic       is_hit_area;
  logic       ball_on;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       hit_pulse;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  ball_motion_ctrl dut (
    .clk_25MHz          (clk_25MHz),
    .reset_n            (reset_n),
    .x_pixel            (x_pixel),
    .y_pixel            (y_pixel),
    .display_en         (display_en),
    .collision_detected (collision_detected),
    .is_hit_area        (is_hit_area),
    .ball_on            (ball_on),
    .ball_x             (ball_x),
    .ball_y             (ball_y),
    .hit_pulse          (hit_pulse),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      x_pixel    = 10'd639;
      y_pixel    = 10'd479;
      display_en = 1'b1;
      tick();
      display_en = 1'b0;
      x_pixel    = '0;
      y_pixel    = '0;
    end
  endtask

  task automatic coll_edge();
    collision_detected = 1'b1;
    tick();
    collision_detected = 1'b0;
    tick();
  endtask

  task automatic probe(input string tag, input int unsigned px, input int unsigned py,
                       input logic exp);
    x_pixel    = 10'(px);
    y_pixel    = 10'(py);
    display_en = 1'b1;
    #1;
    chk({tag, "_hit"}, 32'(is_hit_area), 32'(exp));
    chk({tag, "_on"},  32'(ball_on),     32'(exp));
    display_en = 1'b0;
    x_pixel    = '0;
    y_pixel    = '0;
  endtask

  initial begin
    reset_n = 1'b0; x_pixel = '0; y_pixel = '0;
    display_en = 1'b0; collision_detected = 1'b0;
    repeat (3) tick();
    chk("rst_x", 32'(ball_x), 312);
    chk("rst_y", 32'(ball_y), 100);
    chk("rst_hits", 32'(hit_count), 0);
    chk("rst_miss", 32'(miss_count), 0);
    chk("rst_pulse", 32'(hit_pulse), 0);
    reset_n = 1'b1;
    tick();

    // Frame 0 footprint: x 312..327, y 100..115
    probe("f0_tl", 312, 100, 1'b1);
    probe("f0_br", 327, 115, 1'b1);
    probe("f0_left", 311, 100, 1'b0);
    probe("f0_right", 328, 100, 1'b0);
    probe("f0_above", 312, 99, 1'b0);
    probe("f0_below", 312, 116, 1'b0);
    x_pixel = 10'd320; y_pixel = 10'd108; display_en = 1'b0; #1;
    chk("f0_blank", 32'(is_hit_area), 0);

    frames(1);                                   // F1
    chk("f1_x", 32'(ball_x), 314);
    chk("f1_y", 32'(ball_y), 102);
    probe("f1_old", 313, 102, 1'b0);
    probe("f1_tl", 314, 102, 1'b1);
    probe("f1_br", 329, 117, 1'b1);
    probe("f1_out", 330, 117, 1'b0);

    frames(49);                                  // F50
    chk("f50_x", 32'(ball_x), 412);
    chk("f50_y", 32'(ball_y), 200);

    coll_edge();
    frames(1);                                   // F51: hit accepted
    chk("hit_pulse_on", 32'(hit_pulse), 1);
    chk("hit_y", 32'(ball_y), 198);
    chk("hit_x", 32'(ball_x), 414);
    chk("hit_count1", 32'(hit_count), 1);
    chk("hit_miss0", 32'(miss_count), 0);
    tick();
    chk("hit_pulse_off", 32'(hit_pulse), 0);

    coll_edge();
    frames(1);                                   // F52: cooldown, ignored
    chk("cd_count", 32'(hit_count), 1);
    chk("cd_y", 32'(ball_y), 196);
    chk("cd_pulse", 32'(hit_pulse), 0);

    frames(97);                                  // F149
    chk("f149_y", 32'(ball_y), 2);
    frames(1);                                   // F150: top wall
    chk("top_y", 32'(ball_y), 0);

    frames(5);                                   // F155
    chk("f155_x", 32'(ball_x), 622);
    chk("f155_y", 32'(ball_y), 10);
    frames(1);                                   // F156: right wall
    chk("wall_x", 32'(ball_x), 624);
    frames(1);                                   // F157: now moving left
    chk("wall_x2", 32'(ball_x), 622);
    chk("wall_y2", 32'(ball_y), 14);

    frames(224);                                 // F381
    chk("f381_y", 32'(ball_y), 462);
    chk("f381_x", 32'(ball_x), 174);
    coll_edge();
    frames(1);                                   // F382: hit beats bottom
    chk("hb_y", 32'(ball_y), 460);
    chk("hb_hits", 32'(hit_count), 2);
    chk("hb_miss", 32'(miss_count), 0);
    chk("hb_pulse", 32'(hit_pulse), 1);

    // Reset in the middle of a frame
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mrst_x", 32'(ball_x), 312);
    chk("mrst_y", 32'(ball_y), 100);
    chk("mrst_hits", 32'(hit_count), 0);
    probe("mrst_area", 312, 100, 1'b1);

    frames(181);                                 // F181
    chk("m181_y", 32'(ball_y), 462);
    chk("m181_x", 32'(ball_x), 574);
    frames(1);                                   // F182: miss
    chk("miss_count1", 32'(miss_count), 1);
    chk("miss_hits", 32'(hit_count), 0);
    chk("miss_y", 32'(ball_y), 462);
    chk("miss_x", 32'(ball_x), 572);
    probe("miss_hide_a", 580, 470, 1'b0);
    probe("miss_hide_b", 572, 462, 1'b0);

    coll_edge();
    frames(58);                                  // F240
    chk("miss_edge_hits", 32'(hit_count), 0);
    probe("miss_hide_c", 572, 462, 1'b0);
    frames(1);                                   // F241: last hidden frame
    probe("miss_hide_d", 580, 470, 1'b0);
    chk("miss_hold_x", 32'(ball_x), 572);
    frames(1);                                   // F242: respawn
    chk("resp_x", 32'(ball_x), 312);
    chk("resp_y", 32'(ball_y), 100);
    chk("resp_miss", 32'(miss_count), 1);
    probe("resp_area", 312, 100, 1'b1);
    frames(1);
    chk("resp_x1", 32'(ball_x), 314);
    chk("resp_y1", 32'(ball_y), 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Owns the ball and drives the other end of the hit-detection interface. It keeps the ball's position and velocity, and drives `is_hit_area` and `ball_on` for every pixel of the 640x480 raster. It takes the `collision_detected` flag back from the collision detector and makes the ball bounce. It sits in the 25 MHz VGA pixel domain, between the VGA timing generator and the collision detector/overlay mixer.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `BALL_SIZE`, 16, ball side length in pixels (square)
- `SPEED`, 2, initial speed magnitude per axis, in pixels/frame
- `MAX_SPEED`, 6, speed ceiling (used only with `BALL_SPEEDUP_EN`)
- `COOLDOWN_FRAMES`, 8, frames after a hit during which collisions are ignored
- `RESPAWN_FRAMES`, 60, frames the ball stays hidden after a miss
- `INIT_X`, 312 / `INIT_Y`, 100, spawn position (top-left corner)
- `clk_25MHz` in 1, pixel clock
- `reset_n` in 1, synchronous, active-low reset
- `x_pixel` in 10, current pixel column
- `y_pixel` in 10, current pixel row
- `display_en` in 1, high during the active area
- `collision_detected` in 1, flag from the collision detector; edge-sensitive here
- `is_hit_area` out 1, current pixel lies inside the ball (combinational)
- `ball_on` out 1, draw-ball enable for the mixer (same as `is_hit_area`)
- `ball_x` out 10 / `ball_y` out 10, registered ball top-left position
- `hit_pulse` out 1, one-cycle pulse when a hit is accepted
- `hit_count` out 8 / `miss_count` out 8, wrap-around event counters

## Operation
- **Frame end.** `frame_end = display_en && x_pixel==H_ACTIVE-1 && y_pixel==V_ACTIVE-1`. All motion and state updates happen only on `frame_end` cycles.
- **Collision edge.** `coll_prev` registers `collision_detected`. A rising edge sets `hit_pend`. `hit_pend` is cleared on every `frame_end`, whether or not the hit is accepted.
- **Hit area.** `is_hit_area = display_en && state!=MISS && ball_x<=x_pixel<ball_x+BALL_SIZE && ball_y<=y_pixel<ball_y+BALL_SIZE`. The comparisons use 11-bit unsigned arithmetic.
- **Velocity.** Per axis: sign bit plus 3-bit magnitude `spd`, shared by both axes.
- **MOVE state:**
  - **X axis.** If moving right and `ball_x+spd >= H_ACTIVE-BALL_SIZE`: `ball_x <= H_ACTIVE-BALL_SIZE`, sign flips to left. If moving left and `ball_x <= spd`: `ball_x <= 0`, sign flips to right. Otherwise `ball_x <= ball_x ± spd`.
  - **Top wall.** If moving up and `ball_y <= spd`: `ball_y <= 0`, sign flips to down.
  - **Hit.** If `hit_pend`, the ball is moving down, and state is MOVE: sign flips to up, `ball_y <= ball_y-spd`, `hit_pulse` fires, `hit_count++`, go to COOLDOWN. A hit takes priority over the bottom check in the same frame.
  - **Miss.** If moving down and `ball_y+spd >= V_ACTIVE-BALL_SIZE` with no accepted hit: `miss_count++`, go to MISS.
  - **Otherwise.** `ball_y <= ball_y ± spd`.
- **COOLDOWN.** The ball moves exactly as in MOVE, except collisions are discarded and bottom contact still goes to MISS. A frame counter counts to `COOLDOWN_FRAMES`, then returns to MOVE.
- **MISS.** The ball is hidden and its position is held. After `RESPAWN_FRAMES` frame ends: `ball_x <= INIT_X`, `ball_y <= INIT_Y`, both signs positive (right/down), `spd <= SPEED`, go to MOVE.
- **Discarded edges.** Collision edges arriving in COOLDIWN or MISS, or while the ball moves up, are discarded.

## Timing
- **Reset values** (`reset_n` low at a clock edge):
  - state MOVE; `ball_x=INIT_X`, `ball_y=INIT_Y`
  - velocity +,+ with `spd=SPEED`
  - `hit_pulse=0`, both counts 0, frame counter 0, `coll_prev=0`, `hit_pend=0`
- **Reset mid-frame.** Takes effect on that edge. Positions take the reset values immediately and `is_hit_area` reflects them on the next cycle.
- **Position latency.** Position registers update on the `frame_end` edge. The new position applies from the first pixel of the next frame, so no tearing within a frame.
- **`is_hit_area` / `ball_on`.** Zero-cycle latency relative to `x_pixel`/`y_pixel`.
- **`hit_pulse`.** High for exactly the one cycle following the `frame_end` edge on which the hit is accepted.
- **Collision edge timing.** An edge on the `frame_end` cycle itself is captured into `hit_pend` only on the next cycle, so it counts toward the following frame.

## Configuration
- **`BALL_SPEEDUP_EN` defined.** Each accepted hit sets `spd <= min(spd+1, MAX_SPEED)`. The new speed applies from the next frame's motion. Respawn restores `SPEED`.
- **`BALL_SPEEDUP_EN` undefined.** `spd` is constant at `SPEED`, and `MAX_SPEED` is unused.

## Test plan
- **Reset and first step.** Hold reset, release, run 1 frame: `ball_x`=314, `ball_y`=102; `is_hit_area` is high exactly at x∈[312,327], y∈[100,115] during that frame.
- **Right-wall bounce.** Force `ball_x`=623 moving right: next frame `ball_x`=624 and sign is left; the frame after, `ball_x`=622.
- **Hit accepted.** Raise `collision_detected` mid-frame with the ball moving down at y=200: at frame end `ball_y`=198, `hit_pulse` is 1 cycle, `hit_count`=1. A second edge within the next 8 frames leaves the count unchanged.
- **Miss and respawn.** Let the ball reach y≥462 moving down with no collision: `miss_count`=1 and `is_hit_area` stays 0 for 60 frames; then position is (312,100) with +,+ velocity.
- **Hit and bottom in the same frame.** Edge in the frame where `ball_y`=462: hit wins, `ball_y`=460, `miss_count` unchanged.
- **Speed-up.** With `BALL_SPEEDUP_EN`, five spaced hits give `spd` = 3, 4, 5, 6, 6; a miss restores 2.
